// File: rtl/imem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_pkg : shared constants and FSM encoding for imem_fetch      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package imem_pkg;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 10;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;
endpackage
`default_nettype wire

// File: rtl/imem_fetch_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_fetch_if : clear, load and fetch channels of imem_fetch     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface imem_fetch_if
  import imem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              clear_start;
  logic              busy;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              if_req;
  logic              if_ready;
  logic [ADDR_W+1:0] if_addr;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              if_rack;

  modport master (
    output clear_start, ld_valid, ld_addr, ld_data, if_req, if_addr, if_rack,
    input  busy, ld_ready, if_ready, if_rvalid, if_rdata, if_err
  );

  modport slave (
    input  clear_start, ld_valid, ld_addr, ld_data, if_req, if_addr, if_rack,
    output busy, ld_ready, if_ready, if_rvalid, if_rdata, if_err
  );
endinterface
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_ram : 1W/1R synchronous RAM, registered read-before-write   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // Non-blocking read and write on the same edge give old-data semantics.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | imem_fetch : instruction memory with fetch/load ports and clear  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input wire logic   clk,
  input wire logic   reset_n,
  imem_fetch_if.slave bus
);
  localparam state_t            c_reset_state = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] c_last        = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rvalid;
  logic              r_err;

  logic              w_busy;
  logic              w_ld_ready;
  logic              w_if_ready;
  logic              w_fetch;
  logic              w_misaligned;
  logic              w_ld_we;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_reset_state;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == c_last)   w_state_nxt = ST_IDLE;
      ST_IDLE:  if (bus.clear_start)   w_state_nxt = ST_CLEAR;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  // if_ready is gated by reset_n so it stays low in reset even when no clear follows.
  always_comb begin
    w_busy     = (r_state == ST_CLEAR);
    w_ld_ready = (r_state == ST_IDLE);
    w_if_ready = reset_n && (r_state == ST_IDLE) && !bus.clear_start
                 && (!r_rvalid || bus.if_rack);
  end

  assign w_fetch      = bus.if_req && w_if_ready;
  assign w_misaligned = (bus.if_addr[1:0] != 2'b00);
  assign w_ld_we      = bus.ld_valid && w_ld_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_cnt <= '0;
    else if (w_busy)           r_cnt <= r_cnt + 1'b1;
    else if (bus.clear_start)  r_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_fetch) begin
      r_rvalid <= 1'b1;
      r_err    <= w_misaligned;
    end else if (bus.if_rack) begin
      r_rvalid <= 1'b0;
    end
  end

  // Clear engine owns the write port while busy; loads are refused then.
  assign w_ram_we    = w_busy || w_ld_we;
  assign w_ram_waddr = w_busy ? r_cnt : bus.ld_addr;
  assign w_ram_wdata = w_busy ? '0    : bus.ld_data;
  assign w_ram_re    = w_fetch && !w_misaligned;

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .re    (w_ram_re),
    .raddr (bus.if_addr[ADDR_W+1:2]),
    .rdata (w_ram_rdata)
  );

  assign bus.busy      = w_busy;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.if_ready  = w_if_ready;
  assign bus.if_rvalid = r_rvalid;
  assign bus.if_err    = r_err;
  assign bus.if_rdata  = (r_rvalid && !r_err) ? w_ram_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_imem_fetch : directed bench with a cycle-level reference model|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_imem_fetch;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  imem_fetch #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words remaining to clear, memory image, one response slot.
  logic [31:0] m_mem [DEPTH];
  int          m_left   = DEPTH;
  logic        m_rvalid = 1'b0;
  logic        m_err    = 1'b0;
  logic [31:0] m_rdata  = '0;
  logic        m_acc;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left   = DEPTH;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
    end else begin
      m_acc = bus.if_req && (m_left == 0) && !bus.clear_start && (!m_rvalid || bus.if_rack);
      if (m_acc) begin
        m_rvalid = 1'b1;
        m_err    = (bus.if_addr[1:0] != 2'b00);
        m_rdata  = m_err ? 32'h0 : m_mem[bus.if_addr[11:2]];
      end else if (bus.if_rack) begin
        m_rvalid = 1'b0;
      end
      if (m_left > 0) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
      end else begin
        if (bus.ld_valid)    m_mem[bus.ld_addr] = bus.ld_data;
        if (bus.clear_start) m_left = DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",      {31'b0, bus.busy},      {31'b0, m_left > 0});
    chk("ld_ready",  {31'b0, bus.ld_ready},  {31'b0, m_left == 0});
    chk("if_ready",  {31'b0, bus.if_ready},
        {31'b0, reset_n && (m_left == 0) && !bus.clear_start && (!m_rvalid || bus.if_rack)});
    chk("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, m_rvalid});
    if (m_rvalid) begin
      chk("if_rdata", bus.if_rdata,         m_rdata);
      chk("if_err",   {31'b0, bus.if_err},  {31'b0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    chk(name, n, DEPTH);
    tick();
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  // Acks any held response in the same cycle the new request is accepted.
  task automatic fetch(input logic [AW+1:0] a, input logic [31:0] exp, input logic exp_err,
                       input string name);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    bus.if_rack = 1'b1;
    tick();
    bus.if_req  = 1'b0;
    bus.if_rack = 1'b0;
    chk({name, "_rvalid"}, {31'b0, bus.if_rvalid}, 32'd1);
    chk({name, "_rdata"},  bus.if_rdata,           exp);
    chk({name, "_err"},    {31'b0, bus.if_err},    {31'b0, exp_err});
  endtask

  logic [31:0] b2b_exp [3];

  initial begin
    bus.clear_start = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.if_req      = 1'b0;
    bus.if_addr     = '0;
    bus.if_rack     = 1'b0;

    #12;
    chk("rst_busy",      {31'b0, bus.busy},      32'd1);
    chk("rst_ld_ready",  {31'b0, bus.ld_ready},  32'd0);
    chk("rst_if_ready",  {31'b0, bus.if_ready},  32'd0);
    chk("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    chk("rst_if_rdata",  bus.if_rdata,           32'd0);
    chk("rst_if_err",    {31'b0, bus.if_err},    32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    count_busy("clear_len_reset");

    fetch(12'h000, 32'h0, 1'b0, "f000");
    fetch(12'hFFC, 32'h0, 1'b0, "fffc");

    load(10'd3, 32'h2008_0005);
    fetch(12'h00C, 32'h2008_0005, 1'b0, "f00c");

    load(10'd0, 32'h1111_1111);
    load(10'd1, 32'h2222_2222);
    load(10'd2, 32'h3333_3333);
    b2b_exp[0] = 32'h1111_1111;
    b2b_exp[1] = 32'h2222_2222;
    b2b_exp[2] = 32'h3333_3333;
    bus.if_req  = 1'b1;
    bus.if_rack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.if_addr = 12'(i * 4);
      tick();
      chk($sformatf("b2b_rvalid_%0d", i), {31'b0, bus.if_rvalid}, 32'd1);
      chk($sformatf("b2b_rdata_%0d", i),  bus.if_rdata,           b2b_exp[i]);
    end
    bus.if_req  = 1'b0;
    bus.if_rack = 1'b0;
    tick();
    chk("hold_rdata_a", bus.if_rdata, 32'h3333_3333);
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h000;
    #1;
    chk("stall_if_ready", {31'b0, bus.if_ready}, 32'd0);
    tick();
    bus.if_req = 1'b0;
    chk("hold_rdata_b",  bus.if_rdata,           32'h3333_3333);
    chk("hold_rvalid_b", {31'b0, bus.if_rvalid}, 32'd1);

    fetch(12'h006, 32'h0, 1'b1, "mis006");
    fetch(12'h00C, 32'h2008_0005, 1'b0, "after_mis");

    load(10'd5, 32'h1234_5678);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 10'd5;
    bus.ld_data  = 32'hDEAD_BEEF;
    bus.if_req   = 1'b1;
    bus.if_addr  = 12'h014;
    bus.if_rack  = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_rack  = 1'b0;
    chk("rbw_old", bus.if_rdata, 32'h1234_5678);
    fetch(12'h014, 32'hDEAD_BEEF, 1'b0, "rbw_new");

    // Leave this response unacked across the clear.
    load(10'd7, 32'hCAFE_F00D);
    fetch(12'h01C, 32'hCAFE_F00D, 1'b0, "w7_pre");
    bus.clear_start = 1'b1;
    bus.ld_valid    = 1'b1;
    bus.ld_addr     = 10'd7;
    bus.ld_data     = 32'h0BAD_F00D;
    tick();
    bus.clear_start = 1'b0;
    bus.ld_valid    = 1'b0;
    repeat (100) tick();
    chk("mid_busy",   {31'b0, bus.busy},      32'd1);
    chk("mid_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
    chk("mid_rdata",  bus.if_rdata,           32'hCAFE_F00D);
    bus.if_req  = 1'b1;
    bus.if_addr = 12'h000;
    #1;
    chk("mid_if_ready", {31'b0, bus.if_ready}, 32'd0);
    bus.if_req = 1'b0;

    reset_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    chk("rst_mid_busy",   {31'b0, bus.busy},      32'd1);
    tick();
    reset_n = 1'b1;
    count_busy("clear_len_midreset");

    fetch(12'h01C, 32'h0, 1'b0, "w7_cleared");
    fetch(12'h014, 32'h0, 1'b0, "w5_cleared");
    bus.if_rack = 1'b1;
    tick();
    bus.if_rack = 1'b0;
    chk("final_ack", {31'b0, bus.if_rvalid}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory for the MIPS core, replacing the fixed 1024×32 asynchronous-read imem. Provides a registered fetch port with a valid/acknowledge handshake and a misalignment check, a program-load write port for streaming test images, and a hardware clear engine that zeroes every word on reset or on command. Sits between the fetch stage and the testbench/boot loader.

## Interface
- DATA_W, 32: instruction word width.
- ADDR_W, 10: word-address width; DEPTH = 2**ADDR_W words.
- CLEAR_ON_RESET, 1: 1 = run the clear engine automatically after reset.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear_start  in  1  request zeroing of all DEPTH words.
- busy  out  1  clear engine running.
- ld_valid  in  1  load write request.
- ld_ready  out  1  load accepted this cycle when ld_valid high.
- ld_addr  in  ADDR_W  word address of load.
- ld_data  in  DATA_W  load data.
- if_req  in  1  fetch request.
- if_ready  out  1  fetch accepted this cycle when if_req high.
- if_addr  in  ADDR_W+2  byte address of fetch.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  DATA_W  fetched word (0 on error).
- if_err  out  1  response flags misaligned address.
- if_rack  in  1  consumer takes response this cycle.

## Operation
- States: CLEAR, IDLE. Reset enters CLEAR if CLEAR_ON_RESET else IDLE; clear counter = 0.
- CLEAR: write 0 to word[cnt], cnt++ each cycle; after word DEPTH-1 written, go IDLE. busy=1, ld_ready=0, if_ready=0. clear_start ignored.
- IDLE: clear_start → CLEAR next cycle, cnt=0. ld_ready=1.
- Load: ld_valid && ld_ready writes ld_data to word[ld_addr] at the clock edge.
- Fetch: accepted when if_req && if_ready; if_ready = IDLE && !clear_start && (!if_rvalid || if_rack). Word index = if_addr[ADDR_W+1:2].
- Misaligned (if_addr[1:0] != 0): accepted normally; response if_err=1, if_rdata=0; memory not read.
- Response register: single entry; if_rvalid/if_rdata/if_err held stable until if_rack. if_rack with if_rvalid=0 is ignored.
- Simultaneous load + fetch to the same word: fetch returns the old word (read-before-write).
- clear_start with ld_valid in IDLE: load is written; clear starts next cycle and overwrites it.
- Outstanding response when clear starts: retained until acked; no new fetches until IDLE.

## Timing
- Reset values: busy = CLEAR_ON_RESET, ld_ready = !CLEAR_ON_RESET, if_ready = 0 during reset, if_rvalid=0, if_rdata=0, if_err=0.
- Fetch latency 1 cycle: accepted at edge N, if_rvalid high after edge N, data valid for sampling at edge N+1.
- Throughput 1 fetch/cycle while if_rack held high.
- Clear takes exactly DEPTH cycles; busy falls after the edge writing word DEPTH-1.
- Load write visible to a fetch accepted at the following edge or later.
- reset_n assertion mid-clear or mid-fetch: aborts immediately, response dropped, memory contents not guaranteed (fully zeroed only if CLEAR_ON_RESET reruns).

## Structure
- Package imem_pkg: state encodings (ST_CLEAR, ST_IDLE), default DATA_W/ADDR_W constants.
- Sub-module imem_ram: simple dual-port synchronous RAM, one write port (muxed between clear engine and load), one registered read port, read-before-write; parameters DATA_W, ADDR_W.
- Top holds FSM, clear counter, handshake logic, response register.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=1024 → busy high exactly 1024 cycles; then fetch 0x000, 0xFFC → rdata 0x00000000.
- Load 0x20080005 at word 3, fetch if_addr=0x00C → if_rvalid next cycle, rdata 0x20080005, if_err 0.
- Back-to-back fetches 0x0,0x4,0x8 with if_rack=1 → three responses on consecutive cycles, in order; hold if_rack=0 → if_ready 0, rdata stable.
- Fetch if_addr=0x006 → if_err=1, if_rdata=0; next aligned fetch normal.
- Same-cycle load word 5=0xDEADBEEF and fetch 0x014 (old 0x12345678) → returns 0x12345678; refetch → 0xDEADBEEF.
- clear_start same cycle as load to word 7, then reset_n pulsed mid-clear at cnt=100 → clear restarts from 0, busy for full DEPTH cycles, word 7 reads 0.
